spi_byte_sequencer: RTL



---
 rtl/spi_pkg.sv | 15 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/spi_byte_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI byte sequencer: sequencer state encoding and byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ARM,
        SEQ_XFER,
        SEQ_CAPTURE
    } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together leaves level unchanged.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset (discards contents)
//   push, push_data      write request and data
//   pop                  read request (advances head)
//   full, empty, level   status derived from the count register
//   head                 word at the read pointer, valid while !empty
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == LW'(DEPTH));
    assign empty  = (r_count == '0);
    assign level  = r_count;
    assign head   = r_mem[r_rptr];

    // Requests are qualified here so callers can drive raw valid/ready terms.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count register alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds buffered TX bytes to SPI_driver one at a time and collects each received byte into an RX FIFO.
// Latency: TX byte to drv_start >= 2 cycles; drv_en fall to rx_valid = 2 cycles; CAPTURE to next start gap = 1 cycle.
// Backpressure: tx_ready drops when TX FIFO full; a transfer only starts when the RX FIFO has a slot reserved for it.
//
// Ports:
//   clk, rst                       clock shared with SPI_driver, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready      TX byte stream in
//   rx_data/rx_valid/rx_ready      RX byte stream out (first-word-fall-through)
//   drv_data_in, drv_start         byte and single-cycle start pulse to the driver
//   drv_en, drv_data_out           driver busy flag and received byte from the driver
//   busy                           sequencer not in IDLE
//   tx_level, rx_level             FIFO occupancies
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [BYTE_W-1:0] drv_data_in,
    output logic              drv_start,
    input  logic              drv_en,
    input  logic [BYTE_W-1:0] drv_data_out,
    output logic              busy,
    output logic [LW-1:0]     tx_level,
    output logic [LW-1:0]     rx_level
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              r_start;
    logic              w_start_nxt;
    logic [BYTE_W-1:0] r_data_in;
    logic [BYTE_W-1:0] w_data_in_nxt;
    logic              r_reserve;
    logic              w_reserve_nxt;
    logic              r_en_prev;

    logic              w_tx_full;
    logic              w_tx_empty;
    logic [BYTE_W-1:0] w_tx_head;
    logic              w_tx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [LW-1:0]     w_rx_level;
    logic              w_rx_push;
    logic [LW:0]       w_rx_committed;
    logic              w_rx_room;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (w_tx_pop),
        .full      (w_tx_full),
        .empty     (w_tx_empty),
        .level     (tx_level),
        .head      (w_tx_head)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_rx_push),
        .push_data (drv_data_out),
        .pop       (rx_ready),
        .full      (w_rx_full),
        .empty     (w_rx_empty),
        .level     (w_rx_level),
        .head      (rx_data)
    );

    assign tx_ready    = !w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign rx_level    = w_rx_level;
    assign drv_start   = r_start;
    assign drv_data_in = r_data_in;
    assign busy        = (r_state != SEQ_IDLE);

    // Slots already holding bytes plus the one promised to an in-flight transfer.
    // Starting only when this is below DEPTH makes RX overflow impossible.
    assign w_rx_committed = {1'b0, w_rx_level} + {{LW{1'b0}}, r_reserve};
    assign w_rx_room      = (w_rx_committed < (LW+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEQ_IDLE;
            r_start   <= 1'b0;
            r_data_in <= '0;
            r_reserve <= 1'b0;
            r_en_prev <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start   <= w_start_nxt;
            r_data_in <= w_data_in_nxt;
            r_reserve <= w_reserve_nxt;
            r_en_prev <= drv_en;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_nxt   = 1'b0;
        w_data_in_nxt = r_data_in;
        w_reserve_nxt = r_reserve;
        w_tx_pop      = 1'b0;
        w_rx_push     = 1'b0;

        case (r_state)
            SEQ_IDLE: begin
                // The start pulse is registered, so it is seen by the driver
                // during the first ARM cycle together with the popped byte.
                if (!w_tx_empty && w_rx_room) begin
                    w_tx_pop      = 1'b1;
                    w_data_in_nxt = w_tx_head;
                    w_start_nxt   = 1'b1;
                    w_reserve_nxt = 1'b1;
                    w_state_nxt   = SEQ_ARM;
                end
            end
            SEQ_ARM: begin
                // No timeout: a driver that never raises drv_en parks us here.
                if (drv_en) begin
                    w_state_nxt = SEQ_XFER;
                end
            end
            SEQ_XFER: begin
                if (r_en_prev && !drv_en) begin
                    w_state_nxt = SEQ_CAPTURE;
                end
            end
            SEQ_CAPTURE: begin
                // One cycle after the drv_en fall so drv_data_out has settled.
                // The reservation guarantees a free slot; the full gate is belt-and-braces.
                w_rx_push     = !w_rx_full;
                w_reserve_nxt = 1'b0;
                w_state_nxt   = SEQ_IDLE;
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
    end

endmodule
